// File: rtl/spi_m3_master_seq.sv
// Mode-3 SPI register-access master: frames one command as CS-low, 15-bit address,
// R/W bit and N data bytes, all LSB first, with write-byte stalls and read-byte delivery.
module spi_m3_master_seq #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [14:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HDR,
    ST_FETCH,
    ST_DATA,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        phase_q, phase_d;
  logic [3:0]  hdr_cnt_q, hdr_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  byte_cnt_q, byte_cnt_d;
  logic        rw_q, rw_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_pend_q, rd_pend_d;
  logic        rd_valid_q, rd_valid_d;
  logic        done_q, done_d;
  logic        sck_q, sck_d;
  logic        cs_n_q, cs_n_d;
  logic        mosi_q, mosi_d;
  logic [15:0] hdr_q, hdr_d;
  logic [6:0]  wr_sh_q, wr_sh_d;
  logic [6:0]  rd_sh_q, rd_sh_d;
  logic        miso_s1_q, miso_s2_q;
  logic        last_cnt;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hdr_cnt_d  = hdr_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rw_d       = rw_q;
    rd_data_d  = rd_data_q;
    rd_pend_d  = 1'b0;
    rd_valid_d = rd_pend_q;
    done_d     = 1'b0;
    mosi_d     = mosi_q;
    hdr_d      = hdr_q;
    wr_sh_d    = wr_sh_q;
    rd_sh_d    = rd_sh_q;
    wr_ready   = 1'b0;
    last_cnt   = (cnt_q == DIV_LAST);
    cnt_d      = last_cnt ? 8'd0 : cnt_q + 8'd1;

    case (state_q)
      ST_IDLE: begin
        cnt_d   = 8'd0;
        phase_d = 1'b0;
        if (cmd_valid) begin
          state_d    = ST_SETUP;
          hdr_d      = {cmd_rw, cmd_addr};
          rw_d       = cmd_rw;
          byte_cnt_d = (cmd_len == 8'd0) ? 9'd256 : {1'b0, cmd_len};
          hdr_cnt_d  = 4'd0;
          bit_cnt_d  = 3'd0;
        end
      end
      ST_SETUP: begin
        if (last_cnt) begin
          state_d = ST_HDR;
          phase_d = 1'b0;
          mosi_d  = hdr_q[0];
        end
      end
      ST_HDR: begin
        if (last_cnt) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            hdr_d = hdr_q >> 1;
            if (hdr_cnt_q == 4'd15) begin
              bit_cnt_d = 3'd0;
              if (rw_q) begin
                state_d = ST_DATA;
                phase_d = 1'b0;
                mosi_d  = 1'b0;
              end else begin
                state_d = ST_FETCH;
              end
            end else begin
              hdr_cnt_d = hdr_cnt_q + 4'd1;
              phase_d   = 1'b0;
              mosi_d    = hdr_q[1];
            end
          end
        end
      end
      // Waits with sck high for the next write byte; no edges until it arrives.
      ST_FETCH: begin
        cnt_d = 8'd0;
        if (wr_valid) begin
          wr_ready = 1'b1;
          wr_sh_d  = wr_data[7:1];
          state_d  = ST_DATA;
          phase_d  = 1'b0;
          mosi_d   = wr_data[0];
        end
      end
      ST_DATA: begin
        if (last_cnt) begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            rd_sh_d = {miso_s2_q, rd_sh_q[6:1]};
            wr_sh_d = {1'b0, wr_sh_q[6:1]};
            phase_d = 1'b0;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d  = 3'd0;
              byte_cnt_d = byte_cnt_q - 9'd1;
              if (rw_q) begin
                rd_data_d = {miso_s2_q, rd_sh_q};
                rd_pend_d = 1'b1;
              end
              if (byte_cnt_q == 9'd1) begin
                state_d = ST_HOLD;
              end else if (rw_q) begin
                mosi_d = 1'b0;
              end else begin
                state_d = ST_FETCH;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
              mosi_d    = rw_q ? 1'b0 : wr_sh_q[0];
            end
          end
        end
      end
      ST_HOLD: begin
        if (last_cnt) begin
          state_d = ST_GAP;
          mosi_d  = 1'b0;
        end
      end
      ST_GAP: begin
        if (last_cnt) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin levels follow the next state so they change on the same edge as the state.
    sck_d  = !(((state_d == ST_HDR) || (state_d == ST_DATA)) && !phase_d);
    cs_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      phase_q    <= 1'b0;
      hdr_cnt_q  <= 4'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 9'd0;
      rw_q       <= 1'b0;
      rd_data_q  <= 8'd0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      sck_q      <= 1'b1;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      hdr_cnt_q  <= hdr_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rw_q       <= rw_d;
      rd_data_q  <= rd_data_d;
      rd_pend_q  <= rd_pend_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      sck_q      <= sck_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  always_ff @(posedge clk) begin
    hdr_q     <= hdr_d;
    wr_sh_q   <= wr_sh_d;
    rd_sh_q   <= rd_sh_d;
    miso_s1_q <= miso;
    miso_s2_q <= miso_s1_q;
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign sck       = sck_q;
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_m3_master_seq.sv
// Directed + randomized bench for spi_m3_master_seq with an SPI slave model and
// a bit-list reference of what each frame must put on the wire.
module tb_spi_m3_master_seq;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_rw = 1'b0;
  logic [14:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        miso = 1'b0;
  logic        cmd_ready, wr_ready, rd_valid, busy, done, sck, cs_n, mosi;
  logic [7:0]  rd_data;

  int checks = 0;
  int errors = 0;
  int rises_total = 0, wr_total = 0, done_total = 0, cycnt = 0;
  int cs_rise_cyc = 0, rdy_rise_cyc = 0, sck_bad_total = 0, slave_base = 0;
  logic cs_prev = 1'b1, rdy_prev = 1'b1;
  logic       mosi_log[$];
  logic [7:0] rd_log[$];
  logic [7:0] wbytes[256];
  logic [7:0] sbytes[256];

  spi_m3_master_seq #(.CLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  always @(posedge sck) begin
    if (cs_n === 1'b0) begin
      rises_total++;
      mosi_log.push_back(mosi);
    end
  end

  // Slave: after the 16 header rises, put the next data bit out on each falling edge.
  always @(negedge sck) begin
    if (cs_n === 1'b0) begin
      automatic int k = rises_total - slave_base - 16;
      if (k >= 0 && k < 2048) miso = sbytes[k / 8][k % 8];
    end
  end

  always @(negedge clk) begin
    cycnt++;
    if (wr_ready === 1'b1) wr_total++;
    if (rd_valid === 1'b1) rd_log.push_back(rd_data);
    if (done === 1'b1) done_total++;
    if (cs_n === 1'b1 && sck === 1'b0) sck_bad_total++;
    if (cs_n === 1'b1 && cs_prev === 1'b0) cs_rise_cyc = cycnt;
    if (cmd_ready === 1'b1 && rdy_prev === 1'b0) rdy_rise_cyc = cycnt;
    cs_prev  = cs_n;
    rdy_prev = cmd_ready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_frame(input logic rw, input logic [14:0] addr, input int len_in,
                          input int stall_byte, input int stall_cyc, input int busy_at,
                          input int abort_at, input string tag);
    int n, limit, cyc, ti, stall_wait, r0, bad, me, re;
    int rbase, mbase, wbase, dbase, rdbase, sbbase;
    bit stall_done, aborted;
    logic exp_bits[$];
    n = (len_in == 0) ? 256 : len_in;
    limit = 400 + (16 + 8 * n) * 2 * DIV + 8 * n + stall_cyc + 4 * DIV;
    cyc = 0;
    while (cmd_ready !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    for (int i = 0; i < 15; i++) exp_bits.push_back((addr >> i) & 15'd1);
    exp_bits.push_back(rw);
    for (int b = 0; b < n; b++)
      for (int k = 0; k < 8; k++) exp_bits.push_back(rw ? 1'b0 : wbytes[b][k]);
    rbase = rises_total; mbase = mosi_log.size(); wbase = wr_total;
    dbase = done_total; rdbase = rd_log.size(); sbbase = sck_bad_total;
    slave_base = rises_total;
    stall_wait = 0; stall_done = 0; aborted = 0; cyc = 0;
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_len = 8'(len_in);
    wr_data = wbytes[0];
    wr_valid = !rw && (stall_byte != 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk({tag, "_busy_on_accept"}, {cmd_ready, busy}, 2'b01);
    while (done_total == dbase && cyc < limit) begin
      @(posedge clk); #1; cyc++;
      ti = wr_total - wbase;
      wr_data = wbytes[(ti > 255) ? 255 : ti];
      if (!rw && stall_byte > 0 && ti == stall_byte && !stall_done) begin
        wr_valid = 1'b0;
        if (rises_total - rbase == 16 + 8 * stall_byte) stall_wait++;
        if (stall_wait == 2 * DIV) begin
          r0 = rises_total; bad = 0;
          for (int s = 0; s < stall_cyc; s++) begin
            @(posedge clk); #1; cyc++;
            if (sck !== 1'b1 || cs_n !== 1'b0) bad++;
          end
          chk({tag, "_stall_pins"}, bad, 0);
          chk({tag, "_stall_edges"}, rises_total - r0, 0);
          stall_done = 1; wr_valid = 1'b1;
        end
      end else begin
        wr_valid = !rw && (ti < n);
      end
      if (busy_at > 0 && cyc == busy_at) begin
        cmd_valid = 1'b1; cmd_rw = ~rw; cmd_addr = ~addr; cmd_len = 8'd7;
        chk({tag, "_ready_while_busy"}, cmd_ready, 1'b0);
      end else begin
        cmd_valid = 1'b0;
      end
      if (abort_at > 0 && rises_total - rbase == abort_at && sck === 1'b0) begin
        rst_n = 1'b0; #1;
        chk({tag, "_async_cs_sck"}, {cs_n, sck}, 2'b11);
        chk({tag, "_reset_busy"}, busy, 1'b0);
        wr_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk({tag, "_no_done"}, done_total - dbase, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk({tag, "_ready_after_reset"}, cmd_ready, 1'b1);
        aborted = 1;
        break;
      end
    end
    if (!aborted) begin
      chk({tag, "_timeout"}, (cyc < limit), 1'b1);
      chk({tag, "_rises"}, rises_total - rbase, 16 + 8 * n);
      me = 0;
      for (int i = 0; i < exp_bits.size(); i++)
        if (mosi_log.size() <= mbase + i || mosi_log[mbase + i] !== exp_bits[i]) me++;
      chk({tag, "_mosi_bits_wrong"}, me, 0);
      chk({tag, "_wr_ready_pulses"}, wr_total - wbase, rw ? 0 : n);
      chk({tag, "_rd_valid_pulses"}, rd_log.size() - rdbase, rw ? n : 0);
      if (rw) begin
        re = 0;
        for (int b = 0; b < n; b++)
          if (rd_log.size() <= rdbase + b || rd_log[rdbase + b] !== sbytes[b]) re++;
        chk({tag, "_rd_bytes_wrong"}, re, 0);
      end
      chk({tag, "_cs_gap_ge_div"}, ((rdy_rise_cyc - cs_rise_cyc) >= DIV), 1'b1);
      chk({tag, "_sck_low_cs_high"}, sck_bad_total - sbbase, 0);
      repeat (3) @(posedge clk); #1;
      chk({tag, "_done_once"}, done_total - dbase, 1);
      chk({tag, "_idle_pins"}, {cmd_ready, busy, cs_n, sck, mosi}, 5'b10110);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin wbytes[i] = 8'h00; sbytes[i] = 8'h00; end
    repeat (3) @(posedge clk); #1;
    chk("reset_pins", {cs_n, sck, mosi, rd_valid, wr_ready, done, busy, cmd_ready}, 8'b11000001);
    chk("reset_rd_data", rd_data, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    wbytes[0] = 8'hA5; wbytes[1] = 8'h3C;
    do_frame(1'b0, 15'h0005, 2, 0, 0, 0, 0, "t1_write");

    sbytes[0] = 8'h5A;
    do_frame(1'b1, 15'h0010, 1, 0, 0, 0, 0, "t2_read");

    for (int i = 0; i < 3; i++) wbytes[i] = 8'($urandom);
    do_frame(1'b0, 15'($urandom), 3, 1, 20, 0, 0, "t3_stall");

    for (int i = 0; i < 256; i++) sbytes[i] = 8'($urandom);
    do_frame(1'b1, 15'($urandom), 0, 0, 0, 0, 0, "t4_len0");

    for (int i = 0; i < 4; i++) wbytes[i] = 8'($urandom);
    do_frame(1'b0, 15'($urandom), 2, 0, 0, 0, 19, "t5_abort");
    do_frame(1'b0, 15'($urandom), 2, 0, 0, 0, 0, "t5_fresh");

    for (int i = 0; i < 2; i++) wbytes[i] = 8'($urandom);
    do_frame(1'b0, 15'($urandom), 2, 0, 0, 30, 0, "t6_busy");

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 8; i++) begin wbytes[i] = 8'($urandom); sbytes[i] = 8'($urandom); end
      do_frame(1'($urandom_range(0, 1)), 15'($urandom), $urandom_range(1, 4), 0, 0, 0, 0,
               $sformatf("rnd%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
